// File: rtl/reg_bank_writeback.sv
// reg_bank_writeback: 32x32 MIPS register bank with a one-entry staged write-back.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   RegWrite   - write request, sampled on the rising edge
//   WriteReg   - destination register index (RegDst mux output)
//   WriteData  - value to write
//   ReadReg1   - read port 1 index (rs)
//   ReadReg2   - read port 2 index (rt)
//   ReadData1  - read port 1 data, combinational
//   ReadData2  - read port 2 data, combinational
//   WbPending  - staged write is valid and not yet committed (registered)
//
// Parameters:
//   SP_RESET   - reset value of $29 (stack pointer)
//   RA_RESET   - reset value of $31 (return address)
//
// Optional feature (macro REGBANK_BYPASS_EN):
//   When defined, reads forward the staged entry, giving a read-after-write
//   latency of one edge. When undefined, reads see only the committed array
//   and the read-after-write latency is two edges.
//
// A write request is captured into the stage on one edge and committed to the
// array on the next. Capture and commit share an edge, so consecutive writes
// stream at one per cycle and commit in request order.
module reg_bank_writeback #(
   parameter logic [31:0] SP_RESET = 32'd227,
   parameter logic [31:0] RA_RESET = 32'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        RegWrite,
   input  logic [4:0]  WriteReg,
   input  logic [31:0] WriteData,
   input  logic [4:0]  ReadReg1,
   input  logic [4:0]  ReadReg2,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   output logic        WbPending
);

   localparam logic [4:0] SP_IDX = 5'd29;
   localparam logic [4:0] RA_IDX = 5'd31;

   logic [31:0] regs [32];

   logic        stg_valid;
   logic [4:0]  stg_addr;
   logic [31:0] stg_data;

   logic        capture;

   // Writes aimed at $0 are dropped at capture time, so the stage never
   // holds an entry for $0 and $0 in the array stays at zero.
   assign capture = RegWrite && (WriteReg != 5'd0);

   // Write-back stage. Reset discards any entry that has not committed yet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_valid <= 1'b0;
         stg_addr  <= 5'd0;
         stg_data  <= 32'd0;
      end else begin
         stg_valid <= capture;
         if (capture) begin
            stg_addr <= WriteReg;
            stg_data <= WriteData;
         end
      end
   end

   // Register array. The commit uses the entry captured on the previous
   // edge, so a new capture on this same edge never disturbs it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            if (5'(i) == SP_IDX) begin
               regs[i] <= SP_RESET;
            end else if (5'(i) == RA_IDX) begin
               regs[i] <= RA_RESET;
            end else begin
               regs[i] <= 32'd0;
            end
         end
      end else if (stg_valid) begin
         regs[stg_addr] <= stg_data;
      end
   end

   assign WbPending = stg_valid;

   // Read ports. Index 0 is forced to zero independent of array contents.
   always_comb begin
      ReadData1 = 32'd0;
      ReadData2 = 32'd0;
      if (ReadReg1 != 5'd0) begin
`ifdef REGBANK_BYPASS_EN
         if (stg_valid && (stg_addr == ReadReg1)) begin
            ReadData1 = stg_data;
         end else begin
            ReadData1 = regs[ReadReg1];
         end
`else
         ReadData1 = regs[ReadReg1];
`endif
      end
      if (ReadReg2 != 5'd0) begin
`ifdef REGBANK_BYPASS_EN
         if (stg_valid && (stg_addr == ReadReg2)) begin
            ReadData2 = stg_data;
         end else begin
            ReadData2 = regs[ReadReg2];
         end
`else
         ReadData2 = regs[ReadReg2];
`endif
      end
   end

endmodule

// File: tb/tb_reg_bank_writeback.sv
// tb_reg_bank_writeback: directed and randomized checks of reg_bank_writeback
// against a write-history reference model.
module tb_reg_bank_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic        WbPending;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_bank_writeback dut (
      .clk       (clk),
      .reset     (reset),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2),
      .WbPending (WbPending)
   );

`ifdef REGBANK_BYPASS_EN
   localparam int LAT = 0;
   localparam bit BYP = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      int          e;
   } wr_t;

   // Every accepted write since reset, with the edge that sampled it.
   wr_t hist[$];
   int  edges = 0;
   bit  last_req = 1'b0;

   function automatic logic [31:0] exp_rd(input logic [4:0] r);
      logic [31:0] v;
      if (r == 5'd0) return 32'd0;
      v = (r == 5'd29) ? 32'd227 : 32'd0;
      foreach (hist[i]) begin
         if (hist[i].a == r && hist[i].e + LAT <= edges) v = hist[i].d;
      end
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge: drive, check combinational outputs,
   // take one rising edge, update the model, return after the next fall.
   task automatic cycle(input logic we, input logic [4:0] wr,
                        input logic [31:0] wd, input logic [4:0] r1,
                        input logic [4:0] r2);
      RegWrite  = we;
      WriteReg  = wr;
      WriteData = wd;
      ReadReg1  = r1;
      ReadReg2  = r2;
      #1;
      check("rd1", ReadData1, exp_rd(r1));
      check("rd2", ReadData2, exp_rd(r2));
      check("wbp", {31'd0, WbPending}, {31'd0, last_req});
      @(posedge clk);
      edges++;
      last_req = we && (wr != 5'd0);
      if (last_req) hist.push_back('{a: wr, d: wd, e: edges});
      @(negedge clk);
   endtask

   // Asserts reset mid-cycle and checks the reset state without a clock.
   task automatic do_reset();
      reset    = 1'b1;
      RegWrite = 1'b0;
      hist.delete();
      last_req = 1'b0;
      ReadReg1 = 5'd29;
      ReadReg2 = 5'd31;
      #1;
      check("rst_sp", ReadData1, 32'd227);
      check("rst_ra", ReadData2, 32'd0);
      check("rst_wbp", {31'd0, WbPending}, 32'd0);
      ReadReg1 = 5'd5;
      #1;
      check("rst_r5", ReadData1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset     = 1'b0;
      RegWrite  = 1'b0;
      WriteReg  = 5'd0;
      WriteData = 32'd0;
      ReadReg1  = 5'd0;
      ReadReg2  = 5'd0;
      @(negedge clk);
      #2;
      do_reset();

      // Basic write and bypass window.
      cycle(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0);
      ReadReg1 = 5'd8;
      #1;
      check("byp_win", ReadData1, BYP ? 32'hDEADBEEF : 32'd0);
      check("wbp_after1", {31'd0, WbPending}, 32'd1);
      cycle(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
      ReadReg1 = 5'd8;
      #1;
      check("basic", ReadData1, 32'hDEADBEEF);
      check("wbp_after2", {31'd0, WbPending}, 32'd0);

      // Writes to $0 are dropped.
      cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
      #1;
      check("zero_wbp", {31'd0, WbPending}, 32'd0);
      check("zero_rd", ReadData1, 32'd0);

      // Back-to-back writes to the same register.
      cycle(1'b1, 5'd31, 32'h40, 5'd31, 5'd31);
      check("b2b_wbp1", {31'd0, WbPending}, 32'd1);
      cycle(1'b1, 5'd31, 32'h44, 5'd31, 5'd31);
      check("b2b_wbp2", {31'd0, WbPending}, 32'd1);
      cycle(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
      ReadReg1 = 5'd31;
      #1;
      check("b2b_wbp3", {31'd0, WbPending}, 32'd0);
      check("b2b_val", ReadData1, 32'h44);
      @(negedge clk);

      // Reset lands between capture and commit: the write is lost.
      cycle(1'b1, 5'd9, 32'h55, 5'd9, 5'd8);
      do_reset();
      ReadReg1 = 5'd9;
      ReadReg2 = 5'd8;
      #1;
      check("rstw_r9", ReadData1, 32'd0);
      check("rstw_r8", ReadData2, 32'd0);
      check("rstw_wbp", {31'd0, WbPending}, 32'd0);
      @(negedge clk);

      // Randomized traffic, biased toward a few hot registers.
      for (int i = 0; i < 600; i++) begin
         logic [4:0] wr, r1, r2;
         wr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         r1 = ($urandom_range(0, 1) == 0) ? 5'($urandom) : wr;
         r2 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         if (i % 150 == 149) begin
            do_reset();
         end else begin
            cycle(1'($urandom_range(0, 1)), wr, $urandom, r1, r2);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
